// File: rtl/oport_wrr_pck_arbiter_pkg.sv
// Router-wide shared definitions for the output-port switch arbiter:
// index-width helper, default weight width and the arbiter FSM encoding.
package oport_wrr_pck_arbiter_pkg;

    localparam int unsigned WEIGHTW_DEFAULT = 4;

    // Ceiling log2 with a floor of 1 so single-input instances still get a legal index width.
    function automatic int unsigned log2(input int unsigned n);
        for (int unsigned r = 1; r < 32; r++) begin
            if ((32'd1 << r) >= n) return r;
        end
        return 32;
    endfunction

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/oport_wrr_pck_arbiter_rr_ptr_first_one.sv
// Combinational rotate-from-pointer selector: one-hot of the first request
// found scanning ptr, ptr+1, ... wrapping modulo N.
module rr_ptr_first_one #(
    parameter int unsigned N  = 4,
    parameter int unsigned Nw = 2
) (
    input  logic [N-1:0]  req,
    input  logic [Nw-1:0] ptr,
    output logic [N-1:0]  sel_oh,
    output logic [Nw-1:0] sel_idx,
    output logic          sel_any
);

    int unsigned j;

    always_comb begin
        sel_oh  = '0;
        sel_idx = '0;
        sel_any = 1'b0;
        j       = 0;
        for (int unsigned k = 0; k < N; k++) begin
            // Explicit wrap keeps non-power-of-2 N inside the request vector.
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!sel_any && (j < N) && req[Nw'(j)]) begin
                sel_any         = 1'b1;
                sel_oh[Nw'(j)]  = 1'b1;
                sel_idx         = Nw'(j);
            end
        end
    end

endmodule

// File: rtl/oport_wrr_pck_arbiter.sv
// Per-output-port switch arbiter: packet-granular weighted round-robin among
// N inputs, credit-gated, with the winner holding the port from head to tail.
module oport_wrr_pck_arbiter
    import oport_wrr_pck_arbiter_pkg::*;
#(
    parameter int unsigned N       = 4,
    parameter int unsigned WEIGHTw = WEIGHTW_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N-1:0]           req,
    input  logic [N-1:0]           tail,
    input  logic [N*WEIGHTw-1:0]   weight_all,
    input  logic                   credit_ok,
    output logic [N-1:0]           grant,
    output logic                   grant_valid,
    output logic [log2(N)-1:0]     owner,
    output logic                   locked,
    output logic [N-1:0]           weight_done
);

    localparam int unsigned Nw = log2(N);

    arb_state_e            state_q, state_d;
    logic [Nw-1:0]         ptr_q, ptr_d;
    logic [Nw-1:0]         owner_q, owner_d;
    logic [N-1:0]          wd_q, wd_d;
    logic [WEIGHTw-1:0]    cnt_q [N];
    logic [WEIGHTw-1:0]    cnt_d [N];

    logic [N-1:0]          sel_oh;
    logic [Nw-1:0]         sel_idx;
    logic                  sel_any;
    logic [N-1:0]          grant_c;
    logic [Nw-1:0]         gidx;
    logic [WEIGHTw-1:0]    wsel;

    rr_ptr_first_one #(
        .N  (N),
        .Nw (Nw)
    ) u_sel (
        .req     (req),
        .ptr     (ptr_q),
        .sel_oh  (sel_oh),
        .sel_idx (sel_idx),
        .sel_any (sel_any)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        wd_d    = '0;
        grant_c = '0;
        wsel    = '0;
        gidx    = (state_q == ST_LOCKED) ? owner_q : sel_idx;

        if (!reset) begin
            case (state_q)
                ST_IDLE: begin
                    if (credit_ok && sel_any) begin
                        grant_c = sel_oh;
                        owner_d = sel_idx;
                        if (!tail[sel_idx]) state_d = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    for (int unsigned i = 0; i < N; i++) begin
                        if (Nw'(i) == owner_q) grant_c[i] = req[i] & credit_ok;
                    end
                    if ((|grant_c) && tail[owner_q]) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Quantum accounting happens only when a packet completes (tail granted).
        if ((|grant_c) && tail[gidx]) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (Nw'(i) == gidx) begin
                    if (cnt_q[i] <= WEIGHTw'(1)) begin
                        wsel     = weight_all[i*WEIGHTw +: WEIGHTw];
                        cnt_d[i] = (wsel == '0) ? WEIGHTw'(1) : wsel;
                        ptr_d    = (gidx == Nw'(N-1)) ? '0 : gidx + Nw'(1);
                        wd_d[i]  = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] - WEIGHTw'(1);
                        ptr_d    = gidx;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            wd_q    <= '0;
            for (int unsigned i = 0; i < N; i++) cnt_q[i] <= WEIGHTw'(1);
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            wd_q    <= wd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant       = grant_c;
    assign grant_valid = |grant_c;
    assign owner       = owner_q;
    assign locked      = (state_q == ST_LOCKED);
    assign weight_done = wd_q;

endmodule

// File: tb/tb_oport_wrr_pck_arbiter.sv
// Directed bench for the output-port WRR packet arbiter (N=4 instance plus an N=3 instance).
module tb_oport_wrr_pck_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req, tail, grant, wd;
    logic [15:0] weight_all;
    logic        credit_ok, gv, locked;
    logic [1:0]  owner;

    logic [2:0]  req3, tail3, grant3, wd3;
    logic [11:0] w3;
    logic        cr3, gv3, locked3;
    logic [1:0]  owner3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    oport_wrr_pck_arbiter #(.N(4), .WEIGHTw(4)) dut (
        .clk(clk), .reset(reset), .req(req), .tail(tail), .weight_all(weight_all),
        .credit_ok(credit_ok), .grant(grant), .grant_valid(gv), .owner(owner),
        .locked(locked), .weight_done(wd)
    );

    oport_wrr_pck_arbiter #(.N(3), .WEIGHTw(4)) dut3 (
        .clk(clk), .reset(reset), .req(req3), .tail(tail3), .weight_all(w3),
        .credit_ok(cr3), .grant(grant3), .grant_valid(gv3), .owner(owner3),
        .locked(locked3), .weight_done(wd3)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; req = 4'b1111; tail = 4'b1111; credit_ok = 1'b1; weight_all = 16'h1111;
        tick();
        #1;
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL rst_grant got=%b want=0000", grant); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL rst_locked got=%b want=0", locked); end
        total++; if (owner !== 2'd0) begin bad++; $display("FAIL rst_owner got=%0d want=0", owner); end
        total++; if (wd !== 4'b0000) begin bad++; $display("FAIL rst_wd got=%b want=0000", wd); end
        tick();
        reset = 1'b0;
        #1;
        total++; if (grant !== 4'b0001) begin bad++; $display("FAIL rst_first got=%b want=0001", grant); end
    endtask

    task automatic test_rr_basic;
        logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [1:0] exp_o [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        weight_all = 16'h1111; req = 4'b1111; tail = 4'b1111; credit_ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            total++; if (grant !== exp_g[k]) begin bad++; $display("FAIL rr_grant[%0d] got=%b want=%b", k, grant, exp_g[k]); end
            tick();
            total++; if (owner !== exp_o[k]) begin bad++; $display("FAIL rr_owner[%0d] got=%0d want=%0d", k, owner, exp_o[k]); end
        end
    endtask

    task automatic test_weighted;
        logic [3:0] exp_g [6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic [3:0] exp_w [6] = '{4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic [3:0] pre_g [3] = '{4'b0010, 4'b0100, 4'b1000};
        do_reset();
        weight_all = {4'd1, 4'd1, 4'd1, 4'd3}; tail = 4'b1111; credit_ok = 1'b1;
        // First use of input 0 reloads its counter to 3 and hands priority to input 1.
        req = 4'b0001; #1;
        total++; if (grant !== 4'b0001) begin bad++; $display("FAIL wt_prime got=%b want=0001", grant); end
        tick();
        total++; if (wd !== 4'b0001) begin bad++; $display("FAIL wt_prime_wd got=%b want=0001", wd); end
        req = 4'b1110;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (grant !== pre_g[k]) begin bad++; $display("FAIL wt_pre[%0d] got=%b want=%b", k, grant, pre_g[k]); end
            tick();
        end
        req = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            #1;
            total++; if (grant !== exp_g[k]) begin bad++; $display("FAIL wt_grant[%0d] got=%b want=%b", k, grant, exp_g[k]); end
            tick();
            total++; if (wd !== exp_w[k]) begin bad++; $display("FAIL wt_done[%0d] got=%b want=%b", k, wd, exp_w[k]); end
        end
    endtask

    task automatic test_packet;
        do_reset();
        weight_all = 16'h1111; tail = 4'b1111; credit_ok = 1'b1;
        req = 4'b0011; #1; tick(); #1; tick();   // moves pointer to input 2
        req = 4'b1111; tail = 4'b0000;
        for (int k = 0; k < 2; k++) begin
            #1;
            total++; if (grant !== 4'b0100) begin bad++; $display("FAIL pk_flit[%0d] got=%b want=0100", k, grant); end
            tick();
            total++; if (locked !== 1'b1) begin bad++; $display("FAIL pk_locked[%0d] got=%b want=1", k, locked); end
        end
        total++; if (owner !== 2'd2) begin bad++; $display("FAIL pk_owner got=%0d want=2", owner); end
        req = 4'b1011;
        for (int k = 0; k < 2; k++) begin
            #1;
            total++; if (grant !== 4'b0000) begin bad++; $display("FAIL pk_stall[%0d] got=%b want=0000", k, grant); end
            tick();
            total++; if (locked !== 1'b1) begin bad++; $display("FAIL pk_stall_lock[%0d] got=%b want=1", k, locked); end
        end
        req = 4'b1111; #1;
        total++; if (grant !== 4'b0100) begin bad++; $display("FAIL pk_flit3 got=%b want=0100", grant); end
        tick();
        tail = 4'b0100; #1;
        total++; if (grant !== 4'b0100) begin bad++; $display("FAIL pk_tail got=%b want=0100", grant); end
        tick();
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL pk_unlock got=%b want=0", locked); end
        total++; if (wd !== 4'b0100) begin bad++; $display("FAIL pk_wd got=%b want=0100", wd); end
        tail = 4'b1111; #1;
        total++; if (grant !== 4'b1000) begin bad++; $display("FAIL pk_next got=%b want=1000", grant); end
        tick();
    endtask

    task automatic test_credit;
        do_reset();
        weight_all = 16'h1111; tail = 4'b1111; credit_ok = 1'b1; req = 4'b0011; #1;
        total++; if (grant !== 4'b0001) begin bad++; $display("FAIL cr_first got=%b want=0001", grant); end
        tick();
        credit_ok = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (grant !== 4'b0000 || gv !== 1'b0) begin bad++; $display("FAIL cr_stall[%0d] got=%b/%b want=0000/0", k, grant, gv); end
            tick();
            total++; if (owner !== 2'd0 || wd !== 4'b0000) begin bad++; $display("FAIL cr_hold[%0d] owner=%0d wd=%b want=0/0000", k, owner, wd); end
        end
        credit_ok = 1'b1; #1;
        total++; if (grant !== 4'b0010) begin bad++; $display("FAIL cr_resume got=%b want=0010", grant); end
        tick();
    endtask

    task automatic test_reset_locked;
        do_reset();
        weight_all = 16'h1111; credit_ok = 1'b1; req = 4'b0010; tail = 4'b0000; #1;
        tick();
        total++; if (locked !== 1'b1 || owner !== 2'd1) begin bad++; $display("FAIL rl_setup locked=%b owner=%0d want=1/1", locked, owner); end
        reset = 1'b1; #1;
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL rl_grant got=%b want=0000", grant); end
        total++; if (locked !== 1'b0 || owner !== 2'd0) begin bad++; $display("FAIL rl_state locked=%b owner=%0d want=0/0", locked, owner); end
        tick();
        reset = 1'b0; req = 4'b1111; tail = 4'b1111; #1;
        total++; if (grant !== 4'b0001) begin bad++; $display("FAIL rl_after got=%b want=0001", grant); end
        tick();
    endtask

    task automatic test_n3;
        logic [2:0] exp_g [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        credit_ok = 1'b0; req = 4'b0000;
        do_reset();
        w3 = {4'd0, 4'd1, 4'd1}; req3 = 3'b111; tail3 = 3'b111; cr3 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            total++; if ($isunknown(grant3) || grant3 !== exp_g[k]) begin bad++; $display("FAIL n3_grant[%0d] got=%b want=%b", k, grant3, exp_g[k]); end
            tick();
            total++; if (wd3 !== exp_g[k]) begin bad++; $display("FAIL n3_wd[%0d] got=%b want=%b", k, wd3, exp_g[k]); end
        end
        cr3 = 1'b0; req3 = 3'b000;
    endtask

    initial begin
        reset = 1'b1; req = '0; tail = '0; weight_all = '0; credit_ok = 1'b0;
        req3 = '0; tail3 = '0; w3 = '0; cr3 = 1'b0;
        test_reset();
        test_rr_basic();
        test_weighted();
        test_packet();
        test_credit();
        test_reset_locked();
        test_n3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
